// File: rtl/mult_div_unit.sv
// Iterative 32-step multiply (shift/add) and restoring divide unit with HI/LO result registers.
// Optional feature macro: MULDIV_DIV_EN enables DIV/DIVU; without it only MULT/MULTU are accepted.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mcand_reg;
  logic                 sign_a_reg, sign_b_reg;
  logic [WIDTH-1:0]     hi_reg, lo_reg;

  logic                 op_ok, accept;
  logic                 neg_a, neg_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH-1:0]     load_mcand;
  logic [2*WIDTH-1:0]   load_acc;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step, mul_res;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  // Signed ops (op[0]=0) work on magnitudes; the sign bits drive the FIX correction.
  assign neg_a = ~op[0] & operand_a[WIDTH-1];
  assign neg_b = ~op[0] & operand_b[WIDTH-1];
  assign mag_a = neg_a ? -operand_a : operand_a;
  assign mag_b = neg_b ? -operand_b : operand_b;

  assign accept = (state_reg == IDLE) & start & ~pause & op_ok;

  always_comb begin
    state_next = state_reg;
    if (!pause) begin
      case (state_reg)
        IDLE:    if (start && op_ok) state_next = RUN;
        RUN:     if (cnt_reg == LAST_CNT) state_next = FIX;
        FIX:     state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);

  // Multiply: low half of acc holds the multiplier and is shifted out as the product shifts in.
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
  assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};
  assign mul_res  = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;

`ifdef MULDIV_DIV_EN
  logic               is_div_reg;
  logic [WIDTH-1:0]   dividend_reg;
  logic               dbz_reg;
  logic               fix_dbz;
  logic [WIDTH:0]     div_shift, div_trial;
  logic [2*WIDTH-1:0] div_step;
  logic [WIDTH-1:0]   quo_res, rem_res;

  assign op_ok      = 1'b1;
  assign load_mcand = op[1] ? mag_b : mag_a;
  assign load_acc   = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};

  // Divide: acc = {partial remainder, dividend/quotient}; restore by keeping the shifted value.
  assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, mcand_reg};
  assign div_step  = div_trial[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
  assign acc_next  = is_div_reg ? div_step : mul_step;

  assign quo_res = (sign_a_reg ^ sign_b_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem_res = sign_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_hi  = mul_res[2*WIDTH-1:WIDTH];
    fix_lo  = mul_res[WIDTH-1:0];
    fix_dbz = 1'b0;
    if (is_div_reg) begin
      if (mcand_reg == '0) begin
        fix_hi  = dividend_reg;
        fix_lo  = '1;
        fix_dbz = 1'b1;
      end else begin
        fix_hi = rem_res;
        fix_lo = quo_res;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_div_reg   <= 1'b0;
      dividend_reg <= '0;
    end else if (accept) begin
      is_div_reg   <= op[1];
      dividend_reg <= operand_a;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          dbz_reg <= 1'b0;
    else if (state_reg == FIX && !pause) dbz_reg <= fix_dbz;
  end

  assign div_by_zero = dbz_reg;
`else
  assign op_ok       = ~op[1];
  assign load_mcand  = mag_a;
  assign load_acc    = {{WIDTH{1'b0}}, mag_b};
  assign acc_next    = mul_step;
  assign fix_hi      = mul_res[2*WIDTH-1:WIDTH];
  assign fix_lo      = mul_res[WIDTH-1:0];
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
    end else if (accept) begin
      cnt_reg    <= '0;
      acc_reg    <= load_acc;
      mcand_reg  <= load_mcand;
      sign_a_reg <= neg_a;
      sign_b_reg <= neg_b;
    end else if (state_reg == RUN && !pause) begin
      cnt_reg <= cnt_reg + 1'b1;
      acc_reg <= acc_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (state_reg == FIX && !pause) begin
      hi_reg <= fix_hi;
      lo_reg <= fix_lo;
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected {dbz,hi,lo} queued at start, compared at done.
`timescale 1ns/1ps
module tb_mult_div_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, pause, start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [64:0] exp_q[$];
  logic [31:0] cur_hi, cur_lo;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .pause(pause), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result as {div_by_zero, hi, lo}.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    logic [31:0] q, r;
    case (o)
      2'b00: begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        p  = sa * sb;
        return {1'b0, p};
      end
      2'b01: begin
        p = {32'd0, a} * {32'd0, b};
        return {1'b0, p};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (o == 2'b11) begin
          q = a / b;
          r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = 32'h8000_0000;
          r = 32'd0;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
        end
        return {1'b0, r, q};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int pause_at, input int pause_len, input int hold_done,
                        input bit intrude);
    logic [64:0] e;
    int edges, lat_exp, extra;
    exp_q.push_back(model(o, a, b));
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("busy_accept", busy, 1);
    operand_a = ~a; operand_b = b ^ 32'h5; op = ~o;
    edges = 0;
    lat_exp = 33 + pause_len;
    while (done !== 1'b1 && edges < 200) begin
      pause = (edges >= pause_at) && (edges < pause_at + pause_len);
      start = intrude && (edges == 4);
      @(posedge clk); #1;
      edges++;
      if (edges == lat_exp - 1) begin
        check_val("hi_hold", hi, cur_hi);
        check_val("lo_hold", lo, cur_lo);
      end
    end
    pause = 1'b0; start = 1'b0;
    check_val("latency", edges, lat_exp);
    e = exp_q.pop_front();
    check_val("hi", hi, e[63:32]);
    check_val("lo", lo, e[31:0]);
    check_val("dbz", div_by_zero, e[64]);
    cur_hi = e[63:32];
    cur_lo = e[31:0];
    $display("[TB] op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dbz=%0d lat=%0d",
             o, a, b, hi, lo, div_by_zero, edges);
    if (hold_done > 0) begin
      pause = 1'b1;
      repeat (hold_done) begin
        @(posedge clk); #1;
        check_val("done_hold", done, 1);
      end
      pause = 1'b0;
    end
    @(posedge clk); #1;
    check_val("done_clear", done, 0);
    check_val("busy_clear", busy, 0);
    if (intrude) begin
      extra = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (done === 1'b1 || busy === 1'b1) extra++;
      end
      check_val("no_queued_start", extra, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; pause = 1'b0; start = 1'b0; op = 2'b00;
    operand_a = '0; operand_b = '0; cur_hi = '0; cur_lo = '0;
    #1 reset = 1'b1;
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_hi", hi, 0);
    check_val("rst_lo", lo, 0);
    check_val("rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 99, 0, 0, 1'b0);
    check_val("mult_hi_const", hi, 32'hFFFF_FFFF);
    check_val("mult_lo_const", lo, 32'hFFFF_FFEB);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 99, 0, 0, 1'b1);
    check_val("multu_hi_const", hi, 32'hFFFF_FFFE);
    check_val("multu_lo_const", lo, 32'h0000_0001);

    if (DIV_EN) begin
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 99, 0, 0, 1'b0);
      check_val("div_lo_const", lo, 32'hFFFF_FFFD);
      check_val("div_hi_const", hi, 32'hFFFF_FFFF);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 99, 0, 0, 1'b0);
      run_op(2'b11, 32'd7, 32'd0, 99, 0, 0, 1'b0);
      check_val("divz_flag_const", div_by_zero, 1);
      run_op(2'b10, 32'hFFFF_FF00, 32'd0, 99, 0, 0, 1'b0);
    end
    run_op(2'b01, 32'd2, 32'd3, 99, 0, 0, 1'b0);

    run_op(2'b01, 32'd5, 32'd5, 10, 5, 4, 1'b0);
    check_val("pause_lo_const", lo, 32'd25);

    for (int i = 0; i < 8; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = DIV_EN ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      run_op(ro, ra, rb, (i == 3) ? 20 : 99, (i == 3) ? 2 : 0, 0, 1'b0);
    end

    if (DIV_EN) run_op(2'b11, 32'd9, 32'd0, 99, 0, 0, 1'b0);
    else        run_op(2'b01, 32'h1234_5678, 32'h0000_0100, 99, 0, 0, 1'b0);

    // Abort an operation with an asynchronous reset between edges.
    op = DIV_EN ? 2'b10 : 2'b00; operand_a = 32'd100; operand_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_val("async_busy", busy, 0);
    check_val("async_done", done, 0);
    check_val("async_hi", hi, 0);
    check_val("async_lo", lo, 0);
    check_val("async_dbz", div_by_zero, 0);
    #2 reset = 1'b0;
    cur_hi = '0; cur_lo = '0;
    @(posedge clk); #1;
    check_val("post_rst_idle", busy, 0);

    if (!DIV_EN) begin
      op = 2'b10; operand_a = 32'd50; operand_b = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_val("nodiv_busy", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      check_val("nodiv_done", done, 0);
      check_val("nodiv_busy_late", busy, 0);
      check_val("nodiv_lo", lo, cur_lo);
      $display("[TB] op=2 ignored without divide support, busy=%0d", busy);
    end

    run_op(2'b01, 32'd2, 32'd3, 99, 0, 0, 1'b0);

    if (exp_q.size() != 0) check_val("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit for the MIPS datapath. It takes its two operands straight from the register bank's two read ports and keeps the results in its own HI and LO registers. Those registers are later moved into the bank's write-data path by MFHI/MFLO. Each operation uses a fixed-latency shift/add or restoring-divide sequence with a start/busy/done handshake, so control can stall the pipeline while the unit works.

## Interface
Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.

Ports:
- clk, input, 1: single clock; every state change happens on its rising edge.
- reset, input, 1: asynchronous, active-high; clears all state immediately.
- pause, input, 1: global stall; while high, state, counter and datapath all hold.
- start, input, 1: request an operation; sampled only in IDLE.
- op, input, 2: operation select. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operand_a, input, 32: multiplicand or dividend (from bank read_register_1).
- operand_b, input, 32: multiplier or divisor (from bank read_register_2).
- busy, output, 1: high whenever state is not IDLE.
- done, output, 1: one-cycle completion pulse.
- hi, output, 32: HI register.
- lo, output, 32: LO register.
- div_by_zero, output, 1: sticky flag for the last completed operation.

## Operation
States: IDLE, RUN, FIX, DONE.
- IDLE → RUN: start=1 and pause=0 at an edge.
  - op is latched and operand magnitudes are captured on that edge. Signed ops take the absolute value; the sign bits are kept.
  - Iteration counter is loaded with 0.
- RUN: one iteration per unpaused edge; counter increments.
  - Multiply: conditional add of the multiplicand into a 64-bit accumulator, then shift right 1.
  - Divide: restoring step on a 33-bit partial remainder; one quotient bit per step.
  - Leaves RUN after the 32nd iteration (counter = 31 at that edge).
- FIX: one edge that applies sign correction and writes hi and lo.
  - Multiply: {hi, lo} = 64-bit product, negated if sign_a XOR sign_b (signed op only).
  - Divide: lo = quotient, hi = remainder.
    - Signed quotient is negated if sign_a XOR sign_b; signed remainder takes the sign of the dividend.
    - 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0.
  - Divisor == 0: lo=0xFFFFFFFF, hi=operand_a as captured (unmodified), div_by_zero=1. The unit still runs the full RUN count.
  - Any other completion sets div_by_zero=0.
- DONE: done=1; the next unpaused edge returns to IDLE.

Boundary rules:
- start while busy is ignored and never queued.
- operand and op changes after acceptance are ignored.
- hi and lo keep their previous values until the FIX edge.
- pause=1 freezes every state including DONE, so done stays high for the whole pause.
- reset at any time forces IDLE immediately, without waiting for a clock edge. Effect: busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0, and any operation in progress is discarded.

Reset values: busy 0, done 0, hi 0, lo 0, div_by_zero 0.

## Timing
- start accepted at edge N; busy is high from N until edge N+34.
- RUN iterations occur at edges N+1 through N+32.
- FIX occurs at edge N+33; hi, lo and div_by_zero are valid from N+33 onward.
- done is high between edges N+33 and N+34; IDLE is re-entered at N+34.
- The earliest next start is sampled at edge N+34 (busy=0 in the cycle before).
- Each paused cycle adds exactly one cycle to all of these figures.
- Latency is identical for all ops and operand values.

## Configuration
- MULDIV_DIV_EN defined: all four ops are supported as described above.
- MULDIV_DIV_EN undefined: the divide datapath is removed.
  - start with op[1]=1 is ignored: the unit stays in IDLE, busy and done stay 0, hi and lo are unchanged.
  - div_by_zero is tied to 0.
  - MULT and MULTU timing is unchanged.

## Test plan
- MULT with a=0xFFFFFFFD (-3), b=7, start at edge N → done high after edge N+33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy low after N+34.
- MULTU with a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Immediately follow with a start pulse while busy → ignored, exactly one done pulse.
- DIV with a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_by_zero=0. Then DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU with a=7, b=0 → lo=0xFFFFFFFF, hi=0x00000007, div_by_zero=1 at the 34-cycle completion. A following MULTU 2*3 → lo=6, hi=0, div_by_zero=0.
- MULTU 5*5 with pause held high for 5 cycles mid-RUN → done delayed to after edge N+38; result lo=25. With pause held during DONE → done stays high for the whole pause.
- Reset asserted between clock edges 10 cycles into a DIV → busy, done, hi, lo and div_by_zero go to 0 without waiting for an edge. A later start restarts cleanly. Under no-MULDIV_DIV_EN, a DIV start leaves busy=0.
